// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single-read/single-write CHIP-8 main memory between three
//   requesters: instruction fetch (F), sprite draw (D) and the register
//   load/store/BCD writer (L).
//
//   Arbitration (highest first): current lock owner, starved F, D, L, F.
//   D and L can hold the bus across a burst with *_lock. Reads are tagged
//   with the requester ID so that read data comes back only to the requester
//   that issued the read, exactly two cycles after the accept cycle.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   f_req/f_addr             fetch read request and address
//   f_gnt/f_rvalid/f_rdata   fetch grant, read-return valid and data
//   d_req/d_lock/d_addr      draw read request, bus lock, address
//   d_gnt/d_rvalid/d_rdata   draw grant, read-return valid and data
//   l_req/l_lock/l_we        load/store request, bus lock, write select
//   l_addr/l_wdata           load/store address and write data
//   l_gnt/l_rvalid/l_rdata   load/store grant, read-return valid and data
//   mem_raddr/mem_re         memory read port (registered)
//   mem_waddr/mem_we/mem_d   memory write port (registered)
//   mem_q                    memory read data, sampled one cycle after mem_re
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,

  input  logic                  d_req,
  input  logic                  d_lock,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,

  input  logic                  l_req,
  input  logic                  l_lock,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,

  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_d,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_L    = 2'd2
  } owner_e;

  localparam logic [1:0] ID_F = 2'd0;
  localparam logic [1:0] ID_D = 2'd1;
  localparam logic [1:0] ID_L = 2'd2;

  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

  owner_e                owner_q, owner_d;
  logic [CNT_WIDTH-1:0]  starve_q, starve_d;

  logic [ADDR_WIDTH-1:0] mem_raddr_q, mem_waddr_q;
  logic                  mem_re_q, mem_we_q;
  logic [DATA_WIDTH-1:0] mem_d_q;

  logic                  tag1_vld_q, tag2_vld_q;
  logic [1:0]            tag1_id_q, tag2_id_q;

  logic [DATA_WIDTH-1:0] f_rdata_q, d_rdata_q, l_rdata_q;

  logic                  starved;
  logic                  d_locked, l_locked;
  logic                  rd_acc;
  logic [1:0]            rd_id;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_acc;

  assign starved = (starve_q == STARVE_MAX);

  // A lock only persists while the owner keeps both req and lock high; the
  // first cycle either drops, the owner is released and that same cycle is
  // arbitrated normally.
  assign d_locked = (owner_q == OWN_D) && d_req && d_lock;
  assign l_locked = (owner_q == OWN_L) && l_req && l_lock;

  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (d_locked)               d_gnt = 1'b1;
      else if (l_locked)          l_gnt = 1'b1;
      else if (f_req && starved)  f_gnt = 1'b1;
      else if (d_req)             d_gnt = 1'b1;
      else if (l_req)             l_gnt = 1'b1;
      else if (f_req)             f_gnt = 1'b1;
    end
  end

  always_comb begin
    rd_acc  = 1'b0;
    rd_id   = ID_F;
    rd_addr = f_addr;
    wr_acc  = 1'b0;
    if (f_gnt) begin
      rd_acc  = 1'b1;
      rd_id   = ID_F;
      rd_addr = f_addr;
    end else if (d_gnt) begin
      rd_acc  = 1'b1;
      rd_id   = ID_D;
      rd_addr = d_addr;
    end else if (l_gnt) begin
      rd_acc  = !l_we;
      wr_acc  = l_we;
      rd_id   = ID_L;
      rd_addr = l_addr;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (d_gnt && d_lock)      owner_d = OWN_D;
    else if (l_gnt && l_lock) owner_d = OWN_L;
  end

  always_comb begin
    starve_d = starve_q;
    if (!f_req || f_gnt)  starve_d = '0;
    else if (!starved)    starve_d = starve_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_d_q     <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_id_q   <= ID_F;
      tag2_vld_q  <= 1'b0;
      tag2_id_q   <= ID_F;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      l_rdata_q   <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;

      // Stage 1: present the accepted read to memory and tag it.
      mem_re_q   <= rd_acc;
      tag1_vld_q <= rd_acc;
      tag1_id_q  <= rd_id;
      if (rd_acc) mem_raddr_q <= rd_addr;

      mem_we_q <= wr_acc;
      if (wr_acc) begin
        mem_waddr_q <= l_addr;
        mem_d_q     <= l_wdata;
      end

      // Stage 2: steer memory data to the tagged requester only.
      tag2_vld_q <= tag1_vld_q;
      tag2_id_q  <= tag1_id_q;
      if (tag1_vld_q && tag1_id_q == ID_F) f_rdata_q <= mem_q;
      if (tag1_vld_q && tag1_id_q == ID_D) d_rdata_q <= mem_q;
      if (tag1_vld_q && tag1_id_q == ID_L) l_rdata_q <= mem_q;
    end
  end

  assign mem_raddr = mem_raddr_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_d     = mem_d_q;

  assign f_rvalid  = tag2_vld_q && (tag2_id_q == ID_F);
  assign d_rvalid  = tag2_vld_q && (tag2_id_q == ID_D);
  assign l_rvalid  = tag2_vld_q && (tag2_id_q == ID_L);

  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign l_rdata   = l_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural memory whose read data
//   follows mem_raddr (data is ready one cycle after the address is presented).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          f_req, d_req, d_lock, l_req, l_lock, l_we;
  logic [AW-1:0] f_addr, d_addr, l_addr;
  logic [DW-1:0] l_wdata;
  logic          f_gnt, d_gnt, l_gnt;
  logic          f_rvalid, d_rvalid, l_rvalid;
  logic [DW-1:0] f_rdata, d_rdata, l_rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_d, mem_q;

  logic [DW-1:0] mem [0:4095];

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(16),
    .CNT_WIDTH   (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_lock   (d_lock),
    .d_addr   (d_addr),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .l_req    (l_req),
    .l_lock   (l_lock),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_gnt    (l_gnt),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata),
    .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_d    (mem_d),
    .mem_q    (mem_q)
  );

  assign mem_q = mem[mem_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Inputs change 2 time units after a rising edge; samples follow settling.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    f_req = 0; d_req = 0; d_lock = 0; l_req = 0; l_lock = 0; l_we = 0;
    f_addr = '0; d_addr = '0; l_addr = '0; l_wdata = '0;
  endtask

  int cyc;
  int seen;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h050] = 8'hF0;
    mem[12'h060] = 8'h5A;
    mem[12'h200] = 8'hA5;
    mem[12'h210] = 8'h77;
    mem[12'h300] = 8'h11;
    mem[12'h301] = 8'h22;
    mem[12'h302] = 8'h33;

    // ---- reset with all requests high ----
    idle();
    rst = 1;
    f_req = 1; d_req = 1; l_req = 1;
    d_addr = 12'h050; f_addr = 12'h100; l_addr = 12'h101;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (f_gnt || d_gnt || l_gnt) seen++;
    end
    chk("rst_no_gnt", seen, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_raddr", mem_raddr, 0);
    chk("rst_rvalid", {f_rvalid, d_rvalid, l_rvalid}, 0);
    chk("rst_rdata", {f_rdata, d_rdata, l_rdata}, 0);

    // ---- release: D wins over L and F, two-cycle read latency ----
    rst = 0;
    #1;
    chk("prio_d_gnt", {f_gnt, d_gnt, l_gnt}, 3'b010);
    tick();
    idle();
    chk("prio_raddr", mem_raddr, 12'h050);
    chk("prio_re", mem_re, 1);
    tick();
    chk("prio_d_rvalid", d_rvalid, 1);
    chk("prio_d_rdata", d_rdata, 8'hF0);
    chk("prio_fl_rvalid", {f_rvalid, l_rvalid}, 0);
    tick();
    chk("prio_rvalid_drop", d_rvalid, 0);
    chk("prio_rdata_hold", d_rdata, 8'hF0);

    // ---- lock burst by L while D waits ----
    l_req = 1; l_lock = 1; l_addr = 12'h300;
    #1;
    chk("lock_gnt0", l_gnt, 1);
    tick();
    d_req = 1; d_addr = 12'h060; l_addr = 12'h301;
    #1;
    chk("lock_gnt1", {d_gnt, l_gnt}, 2'b01);
    tick();
    chk("lock_rv0", {l_rvalid, l_rdata}, {1'b1, 8'h11});
    l_addr = 12'h302;
    #1;
    chk("lock_gnt2", {d_gnt, l_gnt}, 2'b01);
    tick();
    chk("lock_rv1", {l_rvalid, l_rdata}, {1'b1, 8'h22});
    l_lock = 0; l_addr = 12'h303;
    #1;
    chk("lock_drop_d_gnt", {d_gnt, l_gnt}, 2'b10);
    tick();
    idle();
    chk("lock_rv2", {l_rvalid, l_rdata}, {1'b1, 8'h33});
    tick();
    chk("lock_d_ret", {d_rvalid, d_rdata, l_rvalid}, {1'b1, 8'h5A, 1'b0});
    tick();

    // ---- starvation guard without lock ----
    d_req = 1; d_addr = 12'h050; f_req = 1; f_addr = 12'h200;
    #1;
    cyc = 0;
    while (!f_gnt && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("starve_cycle", cyc, 16);
    chk("starve_d_blocked", d_gnt, 0);
    tick();
    chk("starve_d_resumes", {f_gnt, d_gnt}, 2'b01);
    tick();
    chk("starve_f_ret", {f_rvalid, f_rdata}, {1'b1, 8'hA5});
    idle();
    tick();

    // ---- starved F still loses to a lock owner ----
    d_req = 1; d_lock = 1; f_req = 1;
    #1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      if (f_gnt) seen++;
      tick();
    end
    chk("lock_blocks_f", seen, 0);
    d_lock = 0;
    #1;
    chk("unlock_f_wins", {f_gnt, d_gnt}, 2'b10);
    tick();
    idle();
    tick();
    tick();

    // ---- BCD-style writes ----
    seen = 0;
    l_req = 1; l_we = 1; l_addr = 12'h400; l_wdata = 8'd1;
    #1;
    chk("bcd_gnt", l_gnt, 1);
    tick();
    if (l_rvalid) seen++;
    chk("bcd_w0", {mem_we, mem_waddr, mem_d}, {1'b1, 12'h400, 8'd1});
    chk("bcd_no_re", mem_re, 0);
    l_addr = 12'h401; l_wdata = 8'd2;
    tick();
    if (l_rvalid) seen++;
    chk("bcd_w1", {mem_we, mem_waddr, mem_d}, {1'b1, 12'h401, 8'd2});
    l_addr = 12'h402; l_wdata = 8'd3;
    tick();
    if (l_rvalid) seen++;
    chk("bcd_w2", {mem_we, mem_waddr, mem_d}, {1'b1, 12'h402, 8'd3});
    idle();
    tick();
    if (l_rvalid) seen++;
    chk("bcd_we_drop", mem_we, 0);
    tick();
    if (l_rvalid) seen++;
    chk("bcd_no_rvalid", seen, 0);

    // ---- reset while a fetch read is in flight ----
    f_req = 1; f_addr = 12'h210;
    #1;
    chk("mid_f_gnt", f_gnt, 1);
    tick();
    idle();
    rst = 1;
    #1;
    chk("mid_re_cleared", mem_re, 0);
    tick();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (f_rvalid) seen++;
      tick();
    end
    chk("mid_no_f_rvalid", seen, 0);
    chk("mid_f_rdata_zero", f_rdata, 0);
    l_req = 1; l_addr = 12'h060; d_req = 1; d_addr = 12'h300;
    #1;
    chk("mid_arb_normal", {f_gnt, d_gnt, l_gnt}, 3'b010);
    tick();
    idle();
    tick();
    chk("mid_d_ret", {d_rvalid, d_rdata}, {1'b1, 8'h11});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-read/single-write 4 KB CHIP-8 main memory between three requesters: the instruction fetch sequencer (F), the sprite draw engine (D) and the register load/store/BCD writer (L).
- Sits between those engines and the `mem` instance.
- Provides fixed priority with a fetch starvation guard, an optional bus lock for multi-byte bursts, and a tagged read-return pipeline so each requester sees only its own data.

Parameters:
- ADDR_WIDTH, 12, memory address width.
- DATA_WIDTH, 8, memory data width.
- STARVE_LIMIT, 16, number of consecutive cycles F may be refused before it is promoted to top priority.
- CNT_WIDTH, 5, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch read request (level).
- f_addr  in  ADDR_WIDTH  fetch read address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  f_rdata valid.
- f_rdata  out  DATA_WIDTH  fetch read data.
- d_req, d_lock  in  1 each  draw read request; hold grant while asserted.
- d_addr  in  ADDR_WIDTH  draw read address.
- d_gnt, d_rvalid  out  1 each.
- d_rdata  out  DATA_WIDTH.
- l_req, l_lock, l_we  in  1 each  load/store request, lock, write select.
- l_addr  in  ADDR_WIDTH.
- l_wdata  in  DATA_WIDTH.
- l_gnt, l_rvalid  out  1 each.
- l_rdata  out  DATA_WIDTH.
- mem_raddr, mem_waddr  out  ADDR_WIDTH  to memory.
- mem_re, mem_we  out  1 each.
- mem_d  out  DATA_WIDTH  write data.
- mem_q  in  DATA_WIDTH  memory read data; valid one cycle after mem_raddr/mem_re are presented.

Behaviour:
- Reset:
  - rst asserted asynchronously clears all registered outputs to 0: mem_re, mem_we, mem_raddr, mem_waddr, mem_d, all *_rvalid, all *_rdata.
  - Also clears the owner register to NONE, the starvation counter to 0 and both tag pipeline stages to invalid.
  - Reset mid-transaction drops in-flight reads; no rvalid is produced for them.
- Grants:
  - *_gnt is combinational from req, owner and the starvation flag.
  - At most one grant is asserted per cycle.
  - A transfer occurs when req and gnt are both high in the same cycle.
- Priority, in decreasing order:
  1. Current lock owner.
  2. F if starved (counter == STARVE_LIMIT).
  3. D.
  4. L.
  5. F.
- Owner FSM, states NONE/D_OWN/L_OWN:
  - Grant to D with d_lock=1 enters D_OWN; grant to L with l_lock=1 enters L_OWN.
  - While owned, only the owner may be granted.
  - The owner state returns to NONE in the first cycle the owner's req or lock is low; that cycle is arbitrated normally.
  - F has no lock.
- Starvation counter:
  - Increments while f_req=1 and f_gnt=0, saturating at STARVE_LIMIT.
  - Clears on f_gnt or when f_req=0.
  - At STARVE_LIMIT, F wins over D and L but never over a lock owner.
- Read path:
  - On an accepted read, the next edge registers mem_raddr=addr and mem_re=1; otherwise mem_re=0 and mem_raddr holds.
  - Tag stage 1 records the requester ID. On the following edge, tag stage 2 captures the ID and the matching *_rdata captures mem_q with *_rvalid=1 for one cycle.
  - Fixed read latency: rvalid is exactly 2 cycles after the accept cycle.
  - Back-to-back accepts are fully pipelined: one read per cycle.
  - *_rdata holds its last value when rvalid=0.
- Write path:
  - An accepted L transfer with l_we=1 registers mem_waddr=l_addr, mem_d=l_wdata and mem_we=1 for exactly one cycle.
  - It produces no rvalid and does not use the read port.
  - Only L may write.
- Simultaneous requests:
  - Resolved strictly by the priority list.
  - Losers keep req asserted and are not queued internally.
  - A requester changing addr while refused is legal; the address sampled at accept is used.
- Address width: addresses pass through unmodified; no wrap or offset logic.

Test Plan:
- Reset: hold rst for 3 cycles with all req=1 -> all outputs 0, no gnt while rst=1. Release -> D granted first.
- Priority and latency: f_req, d_req, l_req all 1 in cycle 0 with d_addr=0x050 and mem[0x050]=0xF0 -> d_gnt in cycle 0, mem_raddr=0x050 and mem_re=1 after edge 1, d_rvalid=1 with d_rdata=0xF0 after edge 2, f_rvalid/l_rvalid stay 0.
- Lock burst: L issues lock reads of 0x300..0x302 while d_req=1 -> three l_gnt, then d_gnt in the cycle l_lock drops, l_rdata returned in order.
- Starvation: D requests continuously without lock, f_req=1 -> f_gnt asserted on cycle 16 (STARVE_LIMIT), counter then cleared, D resumes. With d_lock=1 -> F never granted until the lock drops.
- BCD write: l_we=1 to 0x400/0x401/0x402 with data 1/2/3 on consecutive cycles -> three single-cycle mem_we pulses with matching mem_waddr/mem_d, and no l_rvalid.
- Mid-flight reset: assert rst one cycle after an accepted f read -> no f_rvalid ever appears, pipeline and owner cleared, normal arbitration after release.
